// File: rtl/ddr_req_responder_pkg.sv
// Shared DDR request types and constants for the data mover <-> DDR link.
package ddr_req_responder_pkg;

    // Word-address width of DDR requests (512-bit words).
    localparam int DDR_ADDR_WIDTH = 26;
    localparam int DDR_DATA_WIDTH = 512;

    typedef struct packed {
        logic [DDR_ADDR_WIDTH-1:0] addr;
        logic [DDR_DATA_WIDTH-1:0] data;
    } ddr_wr_t;

    typedef struct packed {
        logic [DDR_ADDR_WIDTH-1:0] addr;
    } ddr_rd_t;

    // Which memory operation the arbiter grants this cycle.
    typedef enum logic [1:0] {
        ISSUE_NONE = 2'd0,
        ISSUE_WR   = 2'd1,
        ISSUE_RD   = 2'd2
    } issue_e;

endpackage

// File: rtl/ddr_req_queue.sv
// Request FIFO: async-read head, registered almost_full, combinational
// overflow pulse on a push that finds the queue full (the push is dropped).
module ddr_req_queue #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int AF_SLACK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(DEPTH - AF_SLACK);
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fill;
    logic             accept;
    logic             take;

    // Fullness is judged on the current fill, so a push into a full queue is
    // dropped even if the head is popped in the same cycle.
    assign empty    = (fill == '0);
    assign full     = (fill == FULL_LEVEL);
    assign accept   = push && !full;
    assign take     = pop && !empty;
    assign overflow = push && full;
    assign head     = store[rd_ptr];

    // Payload storage; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers, fill level and the almost_full flag registered from fill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            almost_full <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (take) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fill        <= fill + CNT_W'(accept) - CNT_W'(take);
            almost_full <= (fill >= AF_LEVEL);
        end
    end

endmodule

// File: rtl/ddr_req_responder.sv
// DDR controller stand-in: queues write/read requests, executes one memory
// operation per cycle against a 512-bit backing store and returns read data
// in issue order after a fixed latency.
module ddr_req_responder
    import ddr_req_responder_pkg::*;
#(
    parameter int MEM_WORDS    = 4096,
    parameter int Q_DEPTH      = 32,
    parameter int AF_SLACK     = 8,
    parameter int RD_LATENCY   = 4,
    parameter int MAX_WR_BURST = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  ddr_wr_t                   ddr_wr_req_data,
    input  logic                      ddr_wr_req_valid,
    output logic                      ddr_wr_req_almost_full,
    input  ddr_rd_t                   ddr_rd_req_data,
    input  logic                      ddr_rd_req_valid,
    output logic                      ddr_rd_req_almost_full,
    output logic [DDR_DATA_WIDTH-1:0] ddr_rd_resp_data,
    output logic                      ddr_rd_resp_valid,
    input  logic                      ddr_rd_resp_almost_full,
    output logic                      req_overflow,
    output logic [31:0]               wr_issued_cnt,
    output logic [31:0]               rd_issued_cnt
);

    localparam int IDX_W    = $clog2(MEM_WORDS);
    localparam int STREAK_W = $clog2(MAX_WR_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_BURST);

    ddr_wr_t              wr_head;
    ddr_rd_t              rd_head;
    logic                 wr_empty;
    logic                 rd_empty;
    logic                 wr_full;
    logic                 rd_full;
    logic                 wr_ovf;
    logic                 rd_ovf;
    logic                 wr_elig;
    logic                 rd_elig;
    logic                 wr_issue;
    logic                 rd_issue;
    issue_e               issue;
    logic [STREAK_W-1:0]  wr_streak;
    logic [IDX_W-1:0]     wr_idx;
    logic [IDX_W-1:0]     rd_idx;
    logic [DDR_DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [DDR_DATA_WIDTH-1:0] mem_q;
    logic [DDR_DATA_WIDTH-1:0] resp_src;
    logic [RD_LATENCY:1]       vld_pipe;
    logic                      unused_addr_bits;
    logic                      unused_full;

    ddr_req_queue #(
        .WIDTH    ($bits(ddr_wr_t)),
        .DEPTH    (Q_DEPTH),
        .AF_SLACK (AF_SLACK)
    ) u_wr_q (
        .clk         (clk),
        .rst         (rst),
        .push        (ddr_wr_req_valid),
        .push_data   (ddr_wr_req_data),
        .pop         (wr_issue),
        .head        (wr_head),
        .empty       (wr_empty),
        .full        (wr_full),
        .almost_full (ddr_wr_req_almost_full),
        .overflow    (wr_ovf)
    );

    ddr_req_queue #(
        .WIDTH    ($bits(ddr_rd_t)),
        .DEPTH    (Q_DEPTH),
        .AF_SLACK (AF_SLACK)
    ) u_rd_q (
        .clk         (clk),
        .rst         (rst),
        .push        (ddr_rd_req_valid),
        .push_data   (ddr_rd_req_data),
        .pop         (rd_issue),
        .head        (rd_head),
        .empty       (rd_empty),
        .full        (rd_full),
        .almost_full (ddr_rd_req_almost_full),
        .overflow    (rd_ovf)
    );

    // Addresses alias modulo MEM_WORDS; the upper bits are intentionally dropped.
    assign wr_idx = wr_head.addr[IDX_W-1:0];
    assign rd_idx = rd_head.addr[IDX_W-1:0];
    assign unused_addr_bits = ^{wr_head.addr, rd_head.addr};
    assign unused_full      = wr_full ^ rd_full;

    // Reads stall while the consumer is near full; writes are never held.
    assign wr_elig = !wr_empty;
    assign rd_elig = !rd_empty && !ddr_rd_resp_almost_full;

    // Grant one operation: writes win until the burst budget is spent.
    always_comb begin
        issue = ISSUE_NONE;
        if (wr_elig && rd_elig) begin
            issue = (wr_streak >= STREAK_MAX) ? ISSUE_RD : ISSUE_WR;
        end else if (wr_elig) begin
            issue = ISSUE_WR;
        end else if (rd_elig) begin
            issue = ISSUE_RD;
        end
    end

    assign wr_issue = (issue == ISSUE_WR);
    assign rd_issue = (issue == ISSUE_RD);

    // Count writes issued past a waiting read; saturates so a read that was
    // throttled while the budget ran out still wins as soon as it is eligible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_streak <= '0;
        end else if (rd_issue || rd_empty) begin
            wr_streak <= '0;
        end else if (wr_issue && (wr_streak < STREAK_MAX)) begin
            wr_streak <= wr_streak + 1'b1;
        end
    end

    // Backing store: one op per cycle, so write and read never collide.
    always_ff @(posedge clk) begin
        if (wr_issue) begin
            mem[wr_idx] <= wr_head.data;
        end
        if (rd_issue) begin
            mem_q <= mem[rd_idx];
        end
    end

    // Read-data delay line; stage 1 is the memory output register.
    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign resp_src = mem_q;
        end else begin : g_latn
            logic [DDR_DATA_WIDTH-1:0] dpipe [2:RD_LATENCY];

            // Shift read data alongside its valid bit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 2; i <= RD_LATENCY; i++) begin
                        dpipe[i] <= '0;
                    end
                end else begin
                    dpipe[2] <= mem_q;
                    for (int i = 3; i <= RD_LATENCY; i++) begin
                        dpipe[i] <= dpipe[i-1];
                    end
                end
            end

            assign resp_src = dpipe[RD_LATENCY];
        end
    endgenerate

    // Valid shift register; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[1] <= rd_issue;
            for (int i = 2; i <= RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign ddr_rd_resp_valid = vld_pipe[RD_LATENCY];
    assign ddr_rd_resp_data  = vld_pipe[RD_LATENCY] ? resp_src : '0;

    // Issue counters (wrap naturally) and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_issued_cnt <= '0;
            rd_issued_cnt <= '0;
            req_overflow  <= 1'b0;
        end else begin
            if (wr_issue) begin
                wr_issued_cnt <= wr_issued_cnt + 32'd1;
            end
            if (rd_issue) begin
                rd_issued_cnt <= rd_issued_cnt + 32'd1;
            end
            if (wr_ovf || rd_ovf) begin
                req_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr_req_responder.sv
// Randomized bench for ddr_req_responder with a queue-based reference model.
module tb_ddr_req_responder;
    import ddr_req_responder_pkg::*;

    localparam int MEM_WORDS    = 4096;
    localparam int Q_DEPTH      = 32;
    localparam int AF_SLACK     = 8;
    localparam int RD_LATENCY   = 4;
    localparam int MAX_WR_BURST = 8;
    localparam int IDX_W        = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    ddr_wr_t       ddr_wr_req_data = '0;
    logic          ddr_wr_req_valid = 1'b0;
    logic          ddr_wr_req_almost_full;
    ddr_rd_t       ddr_rd_req_data = '0;
    logic          ddr_rd_req_valid = 1'b0;
    logic          ddr_rd_req_almost_full;
    logic [511:0]  ddr_rd_resp_data;
    logic          ddr_rd_resp_valid;
    logic          ddr_rd_resp_almost_full = 1'b0;
    logic          req_overflow;
    logic [31:0]   wr_issued_cnt;
    logic [31:0]   rd_issued_cnt;

    always #5 clk = ~clk;

    ddr_req_responder #(
        .MEM_WORDS    (MEM_WORDS),
        .Q_DEPTH      (Q_DEPTH),
        .AF_SLACK     (AF_SLACK),
        .RD_LATENCY   (RD_LATENCY),
        .MAX_WR_BURST (MAX_WR_BURST)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .ddr_wr_req_data         (ddr_wr_req_data),
        .ddr_wr_req_valid        (ddr_wr_req_valid),
        .ddr_wr_req_almost_full  (ddr_wr_req_almost_full),
        .ddr_rd_req_data         (ddr_rd_req_data),
        .ddr_rd_req_valid        (ddr_rd_req_valid),
        .ddr_rd_req_almost_full  (ddr_rd_req_almost_full),
        .ddr_rd_resp_data        (ddr_rd_resp_data),
        .ddr_rd_resp_valid       (ddr_rd_resp_valid),
        .ddr_rd_resp_almost_full (ddr_rd_resp_almost_full),
        .req_overflow            (req_overflow),
        .wr_issued_cnt           (wr_issued_cnt),
        .rd_issued_cnt           (rd_issued_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; logic [511:0] d; } pend_t;
    ddr_wr_t      wq[$];
    ddr_rd_t      rq[$];
    pend_t        pend[$];
    logic [511:0] mmem [int];
    int           streak = 0;
    int           edge_n = 0;
    bit           wr_af_m = 0, rd_af_m = 0, ovf_m = 0;
    int unsigned  wr_cnt_m = 0, rd_cnt_m = 0;
    logic [11:0]  pool [16];

    task automatic model_reset();
        wq.delete(); rq.delete(); pend.delete();
        streak = 0; wr_af_m = 0; rd_af_m = 0; ovf_m = 0;
        wr_cnt_m = 0; rd_cnt_m = 0;
    endtask

    // What happens at one rising edge, from the rules of the block.
    task automatic model_edge();
        int wsz, rsz, idx;
        bit wel, rel, do_rd, do_wr;
        ddr_wr_t w;
        ddr_rd_t r;
        pend_t p;
        edge_n++;
        wsz = wq.size();
        rsz = rq.size();
        wel = wsz > 0;
        rel = (rsz > 0) && !ddr_rd_resp_almost_full;
        do_rd = rel && (!wel || streak >= MAX_WR_BURST);
        do_wr = wel && !do_rd;
        if (do_rd || rsz == 0) streak = 0;
        else if (do_wr) streak = streak + 1;
        if (do_wr) begin
            w = wq.pop_front();
            mmem[int'(w.addr[IDX_W-1:0])] = w.data;
            wr_cnt_m++;
        end
        if (do_rd) begin
            r = rq.pop_front();
            idx = int'(r.addr[IDX_W-1:0]);
            p.due = edge_n + RD_LATENCY - 1;
            p.d = mmem.exists(idx) ? mmem[idx] : '0;
            pend.push_back(p);
            rd_cnt_m++;
        end
        wr_af_m = (wsz >= Q_DEPTH - AF_SLACK);
        rd_af_m = (rsz >= Q_DEPTH - AF_SLACK);
        if (ddr_wr_req_valid) begin
            if (wsz == Q_DEPTH) ovf_m = 1;
            else wq.push_back(ddr_wr_req_data);
        end
        if (ddr_rd_req_valid) begin
            if (rsz == Q_DEPTH) ovf_m = 1;
            else rq.push_back(ddr_rd_req_data);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (pend.size() > 0) && (pend[0].due == edge_n);
        chk("resp_valid", ddr_rd_resp_valid, ev);
        if (ev) begin
            chk("resp_data", ddr_rd_resp_data, pend[0].d);
            pend.delete(0);
        end
        chk("wr_af", ddr_wr_req_almost_full, wr_af_m);
        chk("rd_af", ddr_rd_req_almost_full, rd_af_m);
        chk("overflow", req_overflow, ovf_m);
        chk("wr_cnt", wr_issued_cnt, wr_cnt_m);
        chk("rd_cnt", rd_issued_cnt, rd_cnt_m);
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [25:0] alias_addr(input logic [11:0] idx);
        logic [13:0] hi;
        hi = 14'($urandom());
        return {hi, idx};
    endfunction

    task automatic idle();
        ddr_wr_req_valid = 1'b0;
        ddr_rd_req_valid = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        ddr_rd_resp_almost_full = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_resp_valid", ddr_rd_resp_valid, 1'b0);
        chk("rst_resp_data", ddr_rd_resp_data, '0);
        chk("rst_wr_af", ddr_wr_req_almost_full, 1'b0);
        chk("rst_rd_af", ddr_rd_req_almost_full, 1'b0);
        chk("rst_overflow", req_overflow, 1'b0);
        chk("rst_wr_cnt", wr_issued_cnt, 32'd0);
        chk("rst_rd_cnt", rd_issued_cnt, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_beat(output logic [511:0] d, output int lat);
        lat = -1;
        d = '0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (ddr_rd_resp_valid) begin
                d = ddr_rd_resp_data;
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            ddr_wr_req_valid      = ($urandom_range(0, 99) < 40);
            ddr_wr_req_data.addr  = alias_addr(pool[$urandom_range(0, 15)]);
            ddr_wr_req_data.data  = rnd512();
            ddr_rd_req_valid      = ($urandom_range(0, 99) < 40);
            ddr_rd_req_data.addr  = alias_addr(pool[$urandom_range(0, 15)]);
            ddr_rd_resp_almost_full = ($urandom_range(0, 99) < 15);
            step();
        end
        idle();
        ddr_rd_resp_almost_full = 1'b0;
        repeat (12) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [511:0] a, d1, d2, got;
        int lat, beats, first, last, nrd;
        logic [31:0] base, prev;

        for (int i = 0; i < 16; i++) pool[i] = 12'(12'h100 + i * 65);

        @(negedge clk);
        apply_reset();

        // write then read the same word
        a = rnd512();
        ddr_wr_req_data = '{addr: 26'h10, data: a};
        ddr_wr_req_valid = 1'b1;
        step();
        idle();
        repeat (2) step();
        ddr_rd_req_data.addr = 26'h10;
        ddr_rd_req_valid = 1'b1;
        step();
        idle();
        wait_beat(got, lat);
        chk("wr_rd_data", got, a);
        chk("wr_rd_latency", lat, RD_LATENCY);
        chk("wr_rd_wcnt", wr_issued_cnt, 32'd1);
        chk("wr_rd_rcnt", rd_issued_cnt, 32'd1);

        // aliasing modulo MEM_WORDS
        d1 = rnd512();
        d2 = rnd512();
        ddr_wr_req_data = '{addr: 26'h5, data: d1};
        ddr_wr_req_valid = 1'b1;
        step();
        ddr_wr_req_data = '{addr: 26'h1005, data: d2};
        step();
        idle();
        repeat (2) step();
        ddr_rd_req_data.addr = 26'h5;
        ddr_rd_req_valid = 1'b1;
        step();
        idle();
        wait_beat(got, lat);
        chk("alias_data", got, d2);

        // populate the address pool
        for (int i = 0; i < 16; i++) begin
            ddr_wr_req_data.addr = alias_addr(pool[i]);
            ddr_wr_req_data.data = rnd512();
            ddr_wr_req_valid = 1'b1;
            step();
        end
        idle();
        repeat (4) step();

        run_random(600);

        // both queues busy: reads every 9th cycle
        ddr_rd_resp_almost_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ddr_wr_req_valid = 1'b1;
            ddr_wr_req_data.addr = alias_addr(pool[$urandom_range(0, 15)]);
            ddr_wr_req_data.data = rnd512();
            ddr_rd_req_valid = 1'b1;
            ddr_rd_req_data.addr = alias_addr(pool[$urandom_range(0, 15)]);
            step();
        end
        ddr_rd_req_valid = 1'b0;
        ddr_rd_resp_almost_full = 1'b0;
        prev = rd_issued_cnt;
        last = -1;
        nrd = 0;
        for (int c = 0; c < 100; c++) begin
            ddr_wr_req_data.addr = alias_addr(pool[$urandom_range(0, 15)]);
            ddr_wr_req_data.data = rnd512();
            step();
            if (rd_issued_cnt != prev) begin
                if (last >= 0) chk("rd_gap", c - last, MAX_WR_BURST + 1);
                last = c;
                prev = rd_issued_cnt;
                nrd++;
            end
        end
        idle();
        chk("arb_reads", nrd, 10);
        repeat (30) step();

        // throttle: hold reads, then release
        ddr_rd_resp_almost_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ddr_rd_req_valid = 1'b1;
            ddr_rd_req_data.addr = alias_addr(pool[i]);
            step();
        end
        idle();
        base = rd_issued_cnt;
        beats = 0;
        repeat (10) begin
            step();
            if (ddr_rd_resp_valid) beats++;
        end
        chk("throttle_hold_cnt", rd_issued_cnt - base, 32'd0);
        chk("throttle_hold_beats", beats, 0);
        ddr_rd_resp_almost_full = 1'b0;
        beats = 0;
        first = -1;
        last = -1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (ddr_rd_resp_valid) begin
                beats++;
                if (first < 0) first = c;
                last = c;
            end
        end
        chk("throttle_beats", beats, 10);
        chk("throttle_span", last - first, 9);

        // overflow on the read queue
        ddr_rd_resp_almost_full = 1'b1;
        for (int i = 0; i < Q_DEPTH + 1; i++) begin
            ddr_rd_req_valid = 1'b1;
            ddr_rd_req_data.addr = alias_addr(pool[$urandom_range(0, 15)]);
            step();
        end
        idle();
        step();
        chk("ovf_sticky", req_overflow, 1'b1);
        chk("ovf_rd_af", ddr_rd_req_almost_full, 1'b1);
        ddr_rd_resp_almost_full = 1'b0;
        repeat (45) step();
        chk("ovf_drain_af", ddr_rd_req_almost_full, 1'b0);
        chk("ovf_still_set", req_overflow, 1'b1);

        // reset with 3 reads in flight and 5 queued
        ddr_rd_resp_almost_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ddr_rd_req_valid = 1'b1;
            ddr_rd_req_data.addr = alias_addr(pool[i]);
            step();
        end
        idle();
        ddr_rd_resp_almost_full = 1'b0;
        repeat (3) step();
        ddr_rd_resp_almost_full = 1'b1;
        apply_reset();
        beats = 0;
        repeat (12) begin
            step();
            if (ddr_rd_resp_valid) beats++;
        end
        chk("post_rst_beats", beats, 0);

        // normal traffic after reset
        a = rnd512();
        ddr_wr_req_data = '{addr: alias_addr(pool[3]), data: a};
        ddr_wr_req_valid = 1'b1;
        step();
        idle();
        repeat (2) step();
        ddr_rd_req_data.addr = alias_addr(pool[3]);
        ddr_rd_req_valid = 1'b1;
        step();
        idle();
        wait_beat(got, lat);
        chk("post_rst_data", got, a);
        chk("post_rst_latency", lat, RD_LATENCY);

        run_random(400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
